// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned PKG_ADDR_W = 16;
    localparam logic [4:0]  OPC_HALT   = 5'b00000;

    // Queue entry layout at the default 16-bit address width.
    typedef struct packed {
        logic [INSTR_W-1:0]    instr;
        logic [PKG_ADDR_W-1:0] pc;
        logic [PKG_ADDR_W-1:0] pc_plus2;
    } fq_entry_t;

    typedef enum logic {
        FETCHING = 1'b0,
        HALTED   = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO holding fetched entries; flush empties it, head reads zero when empty.
module fetch_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 48
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, rd_d;
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = empty_o ? '0 : mem_q[rd_q];

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload storage needs no reset: the head is masked while the queue is empty.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, HALT tracking, redirect handling and a small fetch queue to decode.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           FQ_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic                  imem_en,
    input  logic [INSTR_W-1:0]    imem_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INSTR_W-1:0]    out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [ADDR_WIDTH-1:0] out_pc_plus2,
    output logic                  halted,
    output logic                  align_err
);

    localparam int unsigned EW = INSTR_W + 2 * ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pc_plus2;
    fetch_state_e          state_q, state_d;
    logic                  align_err_q, align_err_d;
    logic                  fetch, is_halt;
    logic                  fq_full, fq_empty, fq_pop;
    logic [EW-1:0]         fq_head;

    assign pc_plus2 = pc_q + ADDR_WIDTH'(2);
    assign is_halt  = (imem_data[INSTR_W-1 -: 5] == OPC_HALT);
    // Fetch ignores out_ready so there is no combinational ready-to-memory path.
    assign fetch    = (state_q == FETCHING) && !redirect_valid && !fq_full;
    assign imem_en  = fetch && rst;
    assign imem_addr = pc_q;
    assign halted    = (state_q == HALTED);
    assign align_err = align_err_q;
    assign out_valid = !fq_empty;
    assign fq_pop    = out_valid && out_ready;

    assign {out_instr, out_pc, out_pc_plus2} = fq_head;

    always_comb begin
        pc_d        = pc_q;
        state_d     = state_q;
        align_err_d = 1'b0;
        if (redirect_valid) begin
            pc_d        = {redirect_pc[ADDR_WIDTH-1:1], 1'b0};
            state_d     = FETCHING;
            align_err_d = redirect_pc[0];
        end else if (fetch) begin
            pc_d = pc_plus2;
            if (is_halt) state_d = HALTED;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            state_q     <= FETCHING;
            align_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            state_q     <= state_d;
            align_err_q <= align_err_d;
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .WIDTH (EW)
    ) u_fetch_queue (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (imem_en),
        .pop_i   (fq_pop),
        .flush_i (redirect_valid),
        .data_i  ({imem_data, pc_q, pc_plus2}),
        .head_o  (fq_head),
        .full_o  (fq_full),
        .empty_o (fq_empty)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage against a queue-level behavioural model.
module tb_fetch_stage;

    localparam logic [15:0] RP = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic        imem_en;
    logic [15:0] imem_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [15:0] out_pc_plus2;
    logic        halted;
    logic        align_err;

    always #5 clk = ~clk;

    fetch_stage #(
        .ADDR_WIDTH (16),
        .RESET_PC   (RP),
        .FQ_DEPTH   (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_en        (imem_en),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus2   (out_pc_plus2),
        .halted         (halted),
        .align_err      (align_err)
    );

    logic [15:0] mem [0:32767];
    assign imem_data = mem[imem_addr[15:1]];

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc2;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_pc;
    logic        m_halted;
    logic        m_align;
    int          checks = 0;
    int          failures = 0;

    logic [67:0] obs;
    assign obs = {imem_en, imem_addr, out_valid, out_instr, out_pc, out_pc_plus2, halted, align_err};

    function automatic logic [67:0] exp_vec();
        ent_t h;
        logic e_en, e_valid;
        h = '{16'h0, 16'h0, 16'h0};
        if (mq.size() > 0) h = mq[0];
        e_en    = rst && !m_halted && !redirect_valid && (mq.size() < 2);
        e_valid = (mq.size() > 0);
        return {e_en, m_pc, e_valid, h.instr, h.pc, h.pc2, m_halted, m_align};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc     = RP;
        m_halted = 1'b0;
        m_align  = 1'b0;
    endtask

    // Advance the model by one clock using the current inputs, then move to the next falling edge.
    task automatic tick();
        ent_t        e;
        logic [15:0] w;
        logic        do_fetch, do_pop;
        if (rst) begin
            if (redirect_valid) begin
                mq.delete();
                m_pc     = {redirect_pc[15:1], 1'b0};
                m_halted = 1'b0;
                m_align  = redirect_pc[0];
            end else begin
                m_align  = 1'b0;
                do_fetch = !m_halted && (mq.size() < 2);
                do_pop   = (mq.size() > 0) && out_ready;
                if (do_pop) void'(mq.pop_front());
                if (do_fetch) begin
                    w = mem[m_pc[15:1]];
                    e = '{w, m_pc, 16'(m_pc + 16'd2)};
                    mq.push_back(e);
                    m_pc = m_pc + 16'd2;
                    if (w[15:11] == 5'b00000) m_halted = 1'b1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        redirect_valid = 1'b0;
        #1 model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic fill_linear();
        for (int i = 0; i < 32768; i++) mem[i] = {1'b1, 15'($urandom)};
        for (int i = 0; i < 4; i++) mem[i] = 16'h4000 + 16'(i);
    endtask

    task automatic test_reset();
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        fill_linear();
        #1 model_reset();
        checks++;
        if (obs !== exp_vec()) begin failures++; $display("FAIL reset_async got=%h exp=%h", obs, exp_vec()); end
        @(negedge clk);
        checks++;
        if (obs !== exp_vec()) begin failures++; $display("FAIL reset_held got=%h exp=%h", obs, exp_vec()); end
        checks++;
        if (imem_en !== 1'b0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_idle got en=%b valid=%b exp en=0 valid=0", imem_en, out_valid);
        end
    endtask

    task automatic test_sequential();
        fill_linear();
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++;
            if (obs !== exp_vec()) begin failures++; $display("FAIL seq c%0d got=%h exp=%h", c, obs, exp_vec()); end
            if (c == 2) begin
                checks++;
                if (out_pc !== 16'h0002 || out_instr !== 16'h4001 || out_pc_plus2 !== 16'h0004 || imem_addr !== 16'h0004) begin
                    failures++;
                    $display("FAIL seq_head got pc=%h instr=%h pc2=%h addr=%h exp 0002 4001 0004 0004",
                             out_pc, out_instr, out_pc_plus2, imem_addr);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        fill_linear();
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (obs !== exp_vec()) begin failures++; $display("FAIL bp_stall c%0d got=%h exp=%h", c, obs, exp_vec()); end
            tick();
        end
        #1;
        checks++;
        if (imem_en !== 1'b0 || imem_addr !== 16'h0004 || out_instr !== 16'h4000) begin
            failures++; $display("FAIL bp_full got en=%b addr=%h instr=%h exp 0 0004 4000", imem_en, imem_addr, out_instr);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (obs !== exp_vec()) begin failures++; $display("FAIL bp_release c%0d got=%h exp=%h", c, obs, exp_vec()); end
            tick();
        end
    endtask

    task automatic test_halt();
        fill_linear();
        mem[2] = 16'h0000;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            #1;
            checks++;
            if (obs !== exp_vec()) begin failures++; $display("FAIL halt c%0d got=%h exp=%h", c, obs, exp_vec()); end
            tick();
        end
        #1;
        checks++;
        if (halted !== 1'b1 || imem_addr !== 16'h0006 || imem_en !== 1'b0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL halt_final got h=%b addr=%h en=%b v=%b exp 1 0006 0 0", halted, imem_addr, imem_en, out_valid);
        end
    endtask

    task automatic test_redirect_full();
        fill_linear();
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        redirect_valid = 1'b1; redirect_pc = 16'h0100;
        #1;
        checks++;
        if (obs !== exp_vec()) begin failures++; $display("FAIL redir_req got=%h exp=%h", obs, exp_vec()); end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 16'h0100 || imem_en !== 1'b1) begin
            failures++; $display("FAIL redir_flush got v=%b addr=%h en=%b exp 0 0100 1", out_valid, imem_addr, imem_en);
        end
        tick();
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 16'h0100) begin
            failures++; $display("FAIL redir_target got v=%b pc=%h exp 1 0100", out_valid, out_pc);
        end
        checks++;
        if (obs !== exp_vec()) begin failures++; $display("FAIL redir_after got=%h exp=%h", obs, exp_vec()); end
    endtask

    task automatic test_redirect_halted();
        fill_linear();
        mem[2] = 16'h0000;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        redirect_valid = 1'b1; redirect_pc = 16'h0101;
        #1;
        checks++;
        if (obs !== exp_vec()) begin failures++; $display("FAIL rh_req got=%h exp=%h", obs, exp_vec()); end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || align_err !== 1'b1 || imem_addr !== 16'h0100) begin
            failures++; $display("FAIL rh_align got h=%b ae=%b addr=%h exp 0 1 0100", halted, align_err, imem_addr);
        end
        tick();
        #1;
        checks++;
        if (align_err !== 1'b0 || out_pc !== 16'h0100) begin
            failures++; $display("FAIL rh_pulse got ae=%b pc=%h exp 0 0100", align_err, out_pc);
        end
    endtask

    task automatic test_redirect_pop_full();
        fill_linear();
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'hFFFC;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (obs !== exp_vec()) begin failures++; $display("FAIL rpop_wrap c%0d got=%h exp=%h", c, obs, exp_vec()); end
            tick();
            redirect_valid = 1'b0;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 32768; i++)
            mem[i] = ($urandom_range(15, 0) == 0) ? {5'b00000, 11'($urandom)} : {1'b1, 15'($urandom)};
        do_reset();
        for (int c = 0; c < 800; c++) begin
            out_ready      = ($urandom_range(3, 0) != 0);
            redirect_valid = ($urandom_range(9, 0) == 0);
            redirect_pc    = 16'($urandom);
            #1;
            checks++;
            if (obs !== exp_vec()) begin failures++; $display("FAIL random c%0d got=%h exp=%h", c, obs, exp_vec()); end
            tick();
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset_midstream();
        fill_linear();
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        #2 rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== RP || halted !== 1'b0 || imem_en !== 1'b0) begin
            failures++; $display("FAIL midreset got v=%b addr=%h h=%b en=%b exp 0 %h 0 0", out_valid, imem_addr, halted, imem_en, RP);
        end
        tick();
        #1;
        checks++;
        if (obs !== exp_vec()) begin failures++; $display("FAIL midreset_hold got=%h exp=%h", obs, exp_vec()); end
        rst = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (obs !== exp_vec()) begin failures++; $display("FAIL midreset_resume c%0d got=%h exp=%h", c, obs, exp_vec()); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_halt();
        test_redirect_full();
        test_redirect_halted();
        test_redirect_pop_full();
        test_random();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage feeding the decode stage. Owns the program counter, drives the single-cycle instruction memory (combinational read, 16-bit words, byte addresses with bit 0 = 0) and captures each fetched word with its PC into a 2-entry fetch queue. Decode drains the queue through a valid/ready handshake. The block also handles branch/jump redirects from execute and stops fetching after a HALT.

## Interface
- ADDR_WIDTH, 16, PC and instruction-memory address width
- RESET_PC, 16'h0000, PC value loaded on reset; bit 0 must be 0
- FQ_DEPTH, 2, fetch-queue entries (power of two, ≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset (asserted when 0)
- imem_addr  output  ADDR_WIDTH  byte address to instruction memory (= PC)
- imem_en  output  1  instruction-memory read enable; memory write enable is tied 0 at top level
- imem_data  input  16  instruction word, valid in the same cycle as imem_addr/imem_en
- redirect_valid  input  1  one-cycle request from execute to flush and refetch
- redirect_pc  input  ADDR_WIDTH  redirect target
- out_valid  output  1  queue head valid
- out_ready  input  1  decode accepts head this cycle
- out_instr  output  16  head instruction word
- out_pc  output  ADDR_WIDTH  head instruction address
- out_pc_plus2  output  ADDR_WIDTH  head address + 2, mod 2^ADDR_WIDTH
- halted  output  1  fetch stopped after a HALT was queued
- align_err  output  1  one-cycle pulse: redirect_pc had bit 0 set

## Operation
- Fetch condition: fetch = !halted && !redirect_valid && (count < FQ_DEPTH); imem_en = fetch.
- On fetch edge: push {imem_data, PC, PC+2}; PC <= PC+2; wraps from all-ones-minus-1 to 0 without a flag.
- HALT detect: imem_data[15:11] == 5'b00000. The HALT word is pushed normally; halted <= 1 on the same edge; no further fetch.
- Redirect (highest priority): queue flushed (count <= 0), PC <= {redirect_pc[ADDR_WIDTH-1:1],1'b0}, halted <= 0, no push that cycle. align_err <= redirect_pc[0].
- Pop: out_valid && out_ready removes the head. If a redirect arrives in the same cycle, the pop is discarded by the flush; decode treats that handshake as void.
- Simultaneous push and pop: count is unchanged; the new entry goes behind the remaining entries. Full queue with out_ready=1: no fetch that cycle, because the fetch decision does not depend on out_ready, so there is no ready-to-imem_en path.
- Empty queue: out_valid=0 and out_instr/out_pc/out_pc_plus2 read 0.
- States: FETCHING (halted=0) and HALTED (halted=1). FETCHING -> HALTED on a HALT push. HALTED -> FETCHING only on redirect. The queue keeps draining while HALTED.

## Timing
- Reset (rst=0, asynchronous): PC=RESET_PC, count=0, halted=0, align_err=0, out_valid=0. imem_en=0 while rst=0.
- First fetch on the first rising edge after rst deasserts. out_valid=1 one cycle later.
- Latency: an instruction fetched at edge N is presented at the head after edge N, or later if entries are queued ahead of it.
- Throughput: 1 instruction/cycle with out_ready held high. Count settles at 1.
- Redirect at edge N: the target is fetched in cycle N+1 and reaches out_valid after edge N+1. Redirect held for k cycles suppresses fetch for all k.
- Reset mid-operation clears the queue and any halt immediately.

## Structure
- fetch_pkg: OPC_HALT (5'b00000), INSTR_W (16), a typedef for the queue entry {instr, pc, pc_plus2}.
- Sub-module fetch_queue: parameterised circular FIFO with push, pop, flush, count, head, full, empty.
- fetch_stage holds the PC register, halt flag, fetch/redirect logic and the align_err flop.

## Test plan
- Reset release with RESET_PC=0, memory holding 0x4000..0x4003 at 0..6, out_ready=1 -> imem_addr 0,2,4,6 on consecutive cycles; out_pc 0,2,4,6 with out_instr 0x4000..0x4003; out_pc_plus2 2,4,6,8.
- out_ready=0 for 4 cycles -> exactly 2 fetches (PC 0,2); imem_en=0 afterwards and PC=4; release -> heads 0x4000 then 0x4001, then fetch resumes at 4.
- HALT (0x0000) at address 4 -> entries 0,2,4 delivered; halted=1 after the edge fetching 4; imem_en stays 0; PC holds 6.
- Redirect to 0x0100 while the queue holds 2 entries -> out_valid=0 next cycle; next imem_addr=0x0100; the next out_pc is 0x0100.
- Redirect to 0x0101 while halted -> halted=0; align_err pulses 1 cycle; fetch from 0x0100.
- Redirect coinciding with a pop and with the queue full; reset asserted mid-stream -> queue empty and PC=RESET_PC immediately; no stale instruction emitted.
